// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction-fetch stage and its
// redirect target calculator.
package fetch_pkg;

  localparam logic [1:0] REDIR_BRANCH = 2'd0;
  localparam logic [1:0] REDIR_JUMP   = 2'd1;
  localparam logic [1:0] REDIR_JR     = 2'd2;
  localparam logic [1:0] REDIR_RSVD   = 2'd3;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] PC_STEP_DEFAULT  = 32'd4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request bus and decode hand-off bundled for the fetch stage.
//
// Handshakes: imem_req/imem_addr are held until a cycle with imem_ack=1,
// which completes the request and qualifies imem_rdata in that same cycle.
// inst_valid/inst/inst_pc are held stable until a cycle with inst_ready=1;
// a transfer happens on any edge where inst_valid && inst_ready.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc,
    input  imem_ack, imem_rdata, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc,
    output imem_ack, imem_rdata, inst_ready
  );
endinterface

// File: rtl/next_pc_calc.sv
// Combinational redirect target calculator for branch / jump / jr.
// Also usable by execute for link-address checks.
module next_pc_calc
  import fetch_pkg::*;
(
  input  logic [1:0]  i_redir_kind,
  input  logic [31:0] i_redir_base,
  input  logic [31:0] i_redir_offset,
  input  logic [25:0] i_redir_index,
  input  logic [31:0] i_redir_reg,
  output logic [31:0] o_target,
  output logic        o_misaligned
);

  logic [31:0] w_seq_pc;

  assign w_seq_pc = i_redir_base + 32'd4;

  always_comb begin
    o_target     = 32'h0;
    o_misaligned = 1'b0;
    unique case (i_redir_kind)
      REDIR_BRANCH: o_target = w_seq_pc + (i_redir_offset << 2);
      REDIR_JUMP:   o_target = {w_seq_pc[31:28], i_redir_index, 2'b00};
      REDIR_JR: begin
        o_target     = {i_redir_reg[31:2], 2'b00};
        o_misaligned = (i_redir_reg[1:0] != 2'b00);
      end
      default:      o_target = 32'h0;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues imem requests, buffers one
// word for decode and steers to redirect targets with no delay slot.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  fetch_unit_if.master      bus,
  input  logic              redir_valid,
  input  logic [1:0]        redir_kind,
  input  logic [31:0]       redir_base,
  input  logic [31:0]       redir_offset,
  input  logic [25:0]       redir_index,
  input  logic [31:0]       redir_reg,
  output logic              misalign,
  output state_t            dbg_state
);

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_pc_pend;
  logic [31:0] r_inst;
  logic [31:0] r_inst_pc;
  logic        r_misalign;

  logic [31:0] w_target;
  logic        w_misaligned;
  logic        w_redir;

  next_pc_calc u_next_pc_calc (
    .i_redir_kind   (redir_kind),
    .i_redir_base   (redir_base),
    .i_redir_offset (redir_offset),
    .i_redir_index  (redir_index),
    .i_redir_reg    (redir_reg),
    .o_target       (w_target),
    .o_misaligned   (w_misaligned)
  );

  assign w_redir = redir_valid && (redir_kind != REDIR_RSVD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_pc_pend  <= 32'h0;
      r_inst     <= 32'h0;
      r_inst_pc  <= 32'h0;
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= w_redir && w_misaligned;
      unique case (r_state)
        S_IDLE: begin
          if (w_redir) r_pc <= w_target;
          r_state <= S_REQ;
        end
        S_REQ: begin
          if (w_redir) begin
            // Without ack the bus must keep the old address; park the target.
            if (bus.imem_ack) begin
              r_pc    <= w_target;
              r_state <= S_REQ;
            end else begin
              r_pc_pend <= w_target;
              r_state   <= S_DROP;
            end
          end else if (bus.imem_ack) begin
            r_inst    <= bus.imem_rdata;
            r_inst_pc <= r_pc;
            r_pc      <= r_pc + PC_STEP;
            r_state   <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (w_redir) begin
            r_pc    <= w_target;
            r_state <= S_REQ;
          end else if (bus.inst_ready) begin
            r_state <= S_REQ;
          end
        end
        S_DROP: begin
          if (bus.imem_ack) begin
            r_pc    <= w_redir ? w_target : r_pc_pend;
            r_state <= S_REQ;
          end else if (w_redir) begin
            r_pc_pend <= w_target;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.imem_req   = (r_state == S_REQ) || (r_state == S_DROP);
  assign bus.imem_addr  = r_pc;
  assign bus.inst_valid = (r_state == S_HOLD);
  assign bus.inst       = r_inst;
  assign bus.inst_pc    = r_inst_pc;
  assign misalign       = r_misalign;
  assign dbg_state      = r_state;

endmodule
